// File: rtl/cache_pkg.sv
// Shared types, default geometry and address-field helpers for the data cache.
package cache_pkg;

  localparam int ADDR_SIZE   = 12;
  localparam int INDEX_BITS  = 4;
  localparam int OFFSET_BITS = 2;
  localparam int TAG_BITS    = ADDR_SIZE - INDEX_BITS - OFFSET_BITS;
  localparam int DATA_WIDTH  = 32;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    RESP
  } cacheState_t;

  // Helpers take the field widths as arguments so they work for any geometry;
  // callers size-cast the result down to the field width.
  function automatic logic [31:0] tagOf(input logic [31:0] addr, input int indexBits,
                                        input int offsetBits);
    return addr >> (indexBits + offsetBits);
  endfunction

  function automatic logic [31:0] indexOf(input logic [31:0] addr, input int indexBits,
                                          input int offsetBits);
    return (addr >> offsetBits) & ((32'd1 << indexBits) - 32'd1);
  endfunction

  function automatic logic [31:0] offsetOf(input logic [31:0] addr, input int offsetBits);
    return addr & ((32'd1 << offsetBits) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Per-line valid/dirty/tag state with a single lookup index and update strobes.
module cache_tag_store
  import cache_pkg::*;
#(
  parameter int index = INDEX_BITS,
  parameter int tag   = TAG_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [index-1:0] lineIdx,
  input  logic [tag-1:0]   newTag,
  input  logic             setDirty,
  input  logic             clrDirty,
  input  logic             fillLine,
  output logic             lineValid,
  output logic             lineDirty,
  output logic [tag-1:0]   lineTag
);

  localparam int LINES = 1 << index;

  logic [LINES-1:0] validBits;
  logic [LINES-1:0] dirtyBits;
  logic [tag-1:0]   tagArr [LINES];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validBits <= '0;
      dirtyBits <= '0;
    end else if (fillLine) begin
      validBits[lineIdx] <= 1'b1;
      dirtyBits[lineIdx] <= 1'b0;
    end else if (setDirty) begin
      dirtyBits[lineIdx] <= 1'b1;
    end else if (clrDirty) begin
      dirtyBits[lineIdx] <= 1'b0;
    end
  end

  // NOTE: storage arrays carry no reset; the valid bits alone make stale tags harmless,
  // and leaving them unreset lets the array map onto RAM.
  always_ff @(posedge clk) begin
    if (fillLine) tagArr[lineIdx] <= newTag;
  end

  assign lineValid = validBits[lineIdx];
  assign lineDirty = dirtyBits[lineIdx];
  assign lineTag   = tagArr[lineIdx];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache sequencer with word-serial memory bursts.
// Define CACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module cache_controller
  import cache_pkg::*;
#(
  parameter int addrSize  = ADDR_SIZE,
  parameter int index     = INDEX_BITS,
  parameter int offset    = OFFSET_BITS,
  parameter int tag       = addrSize - index - offset,
  parameter int dataWidth = DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [addrSize-1:0]  cpu_addr,
  input  logic [dataWidth-1:0] cpu_wdata,
  output logic [dataWidth-1:0] cpu_rdata,
  output logic                 cpu_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [addrSize-1:0]  mem_addr,
  output logic [dataWidth-1:0] mem_wdata,
  input  logic [dataWidth-1:0] mem_rdata,
  input  logic                 mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);

  localparam int WORDS = 1 << (index + offset);

  cacheState_t          state, stateNext;
  logic                 reqWe;
  logic [addrSize-1:0]  reqAddr;
  logic [dataWidth-1:0] reqWdata;
  logic [tag-1:0]       reqTag, lineTag, burstTag;
  logic [index-1:0]     reqIdx;
  logic [offset-1:0]    reqOff, cnt, cntNext;
  logic                 lineValid, lineDirty, hit, memAck, lastWord;
  logic                 setDirty, clrDirty, fillLine;
  logic [dataWidth-1:0] dataArr [WORDS];

  assign reqTag   = tag'(tagOf(32'(reqAddr), index, offset));
  assign reqIdx   = index'(indexOf(32'(reqAddr), index, offset));
  assign reqOff   = offset'(offsetOf(32'(reqAddr), offset));
  assign hit      = lineValid && (lineTag == reqTag);
  assign memAck   = mem_req && mem_ack;
  assign lastWord = &cnt;
  assign cntNext  = cnt + offset'(1);
  assign burstTag = (state == WRITEBACK) ? lineTag : reqTag;

  cache_tag_store #(.index(index), .tag(tag)) tagStore (
    .clk      (clk),
    .rst      (rst),
    .lineIdx  (reqIdx),
    .newTag   (reqTag),
    .setDirty (setDirty),
    .clrDirty (clrDirty),
    .fillLine (fillLine),
    .lineValid(lineValid),
    .lineDirty(lineDirty),
    .lineTag  (lineTag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    stateNext = state;
    setDirty  = 1'b0;
    clrDirty  = 1'b0;
    fillLine  = 1'b0;
    case (state)
      IDLE:      if (cpu_req) stateNext = COMPARE;
      COMPARE: begin
        if (hit) begin
          setDirty  = reqWe;
          stateNext = RESP;
        end else begin
          stateNext = lineDirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: if (memAck && lastWord) begin
        clrDirty  = 1'b1;
        stateNext = ALLOCATE;
      end
      ALLOCATE:  if (memAck && lastWord) begin
        fillLine  = 1'b1;
        stateNext = COMPARE;
      end
      RESP:      stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == COMPARE && hit && reqWe) dataArr[{reqIdx, reqOff}] <= reqWdata;
    else if (state == ALLOCATE && memAck) dataArr[{reqIdx, cnt}] <= mem_rdata;
  end

  // Each burst opens with mem_req low; the first cycle in the state issues word 0,
  // and each ack advances the word until the counter wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reqWe     <= 1'b0;
      reqAddr   <= '0;
      reqWdata  <= '0;
      cnt       <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      cpu_ready <= (state == RESP);
      case (state)
        IDLE: if (cpu_req) begin
          reqWe    <= cpu_we;
          reqAddr  <= cpu_addr;
          reqWdata <= cpu_wdata;
        end
        COMPARE: if (hit && !reqWe) cpu_rdata <= dataArr[{reqIdx, reqOff}];
        WRITEBACK, ALLOCATE: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= (state == WRITEBACK);
            mem_addr <= {burstTag, reqIdx, cnt};
            if (state == WRITEBACK) mem_wdata <= dataArr[{reqIdx, cnt}];
          end else if (mem_ack) begin
            cnt <= cntNext;
            if (lastWord) begin
              mem_req <= 1'b0;
            end else begin
              mem_addr <= {burstTag, reqIdx, cntNext};
              if (state == WRITEBACK) mem_wdata <= dataArr[{reqIdx, cntNext}];
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic firstCompare;

  // Only the first COMPARE of a request is counted; the post-refill retry is not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      firstCompare <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      if (state == IDLE && cpu_req) firstCompare <= 1'b1;
      if (state == COMPARE) begin
        firstCompare <= 1'b0;
        if (firstCompare) begin
          if (hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
          if (!hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
        end
      end
    end
  end
`endif

endmodule
